// File: rtl/trap_ctrl.sv
// trap_ctrl - machine-mode trap sequencer sitting in front of the CSR file.
//
// Optional build macro: TRAP_VECTORED_EN (vectored mtvec mode; default off).
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   irq_ext_i, irq_timer_i        level interrupt requests
//   mret_i, pc_i                  MRET qualifier and PC of the execute-stage instruction
//   core_csr_*_i                  CSR access requested by the core (passed through when idle)
//   csr_*_o, csr_rdata_i          single access port of the CSR file
//   stall_o, flush_o              pipeline freeze / kill-younger controls
//   redirect_valid_o, redirect_pc_o  one-cycle PC redirect to fetch
//
// While idle the core owns the CSR port. An enabled interrupt or an MRET takes
// the port over, runs the CSR update sequence and ends with a single redirect.
module trap_ctrl #(
   parameter int unsigned       DW           = 32,
   parameter int unsigned       ADDRW        = 12,
   parameter logic [ADDRW-1:0]  MSTATUS_ADDR = ADDRW'(12'h300),
   parameter logic [ADDRW-1:0]  MIE_ADDR     = ADDRW'(12'h304),
   parameter logic [ADDRW-1:0]  MTVEC_ADDR   = ADDRW'(12'h305),
   parameter logic [ADDRW-1:0]  MEPC_ADDR    = ADDRW'(12'h341),
   parameter logic [ADDRW-1:0]  MCAUSE_ADDR  = ADDRW'(12'h342)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             irq_ext_i,
   input  logic             irq_timer_i,
   input  logic             mret_i,
   input  logic [DW-1:0]    pc_i,
   input  logic [ADDRW-1:0] core_csr_addr_i,
   input  logic             core_csr_we_i,
   input  logic             core_csr_re_i,
   input  logic [DW-1:0]    core_csr_wdata_i,
   output logic [ADDRW-1:0] csr_addr_o,
   output logic             csr_we_o,
   output logic             csr_re_o,
   output logic [DW-1:0]    csr_wdata_o,
   input  logic [DW-1:0]    csr_rdata_i,
   output logic             stall_o,
   output logic             flush_o,
   output logic             redirect_valid_o,
   output logic [DW-1:0]    redirect_pc_o
);

   localparam int unsigned        CAUSE_W   = 4;
   localparam logic [CAUSE_W-1:0] CAUSE_EXT = CAUSE_W'(11);
   localparam logic [CAUSE_W-1:0] CAUSE_TMR = CAUSE_W'(7);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      T_EPC   = 3'd1,
      T_CAUSE = 3'd2,
      T_STAT  = 3'd3,
      T_VEC   = 3'd4,
      M_STAT  = 3'd5,
      M_VEC   = 3'd6
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DW-1:0]        mstatus_sh;
   logic                 meie_sh;
   logic                 mtie_sh;
   logic [DW-1:0]        epc_q;
   logic [CAUSE_W-1:0]   cause_q;
   logic [DW-1:0]        redir_pc_q;
   logic                 pend;
   logic [CAUSE_W-1:0]   cause_sel;
   logic [DW-1:0]        mstat_trap;
   logic [DW-1:0]        mstat_mret;
   logic [DW-1:0]        vec_base;
   logic [DW-1:0]        vec_target;

   // Interrupt qualification against the shadowed enables; external wins.
   assign pend      = mstatus_sh[3] & ((irq_ext_i & meie_sh) | (irq_timer_i & mtie_sh));
   assign cause_sel = (irq_ext_i & meie_sh) ? CAUSE_EXT : CAUSE_TMR;

   // mstatus images written on trap entry and on MRET.
   always_comb begin
      mstat_trap        = mstatus_sh;
      mstat_trap[7]     = mstatus_sh[3];
      mstat_trap[3]     = 1'b0;
      mstat_trap[12:11] = 2'b11;
      mstat_mret        = mstatus_sh;
      mstat_mret[3]     = mstatus_sh[7];
      mstat_mret[7]     = 1'b1;
      mstat_mret[12:11] = 2'b11;
   end

   // Handler target from the mtvec value returned this cycle.
   assign vec_base = {csr_rdata_i[DW-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
   assign vec_target = (csr_rdata_i[1:0] == 2'b01) ? vec_base + (DW'(cause_q) << 2) : vec_base;
`else
   assign vec_target = vec_base;
`endif

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an interrupt beats a simultaneous MRET.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pend) begin
               state_nxt = T_EPC;
            end else if (mret_i) begin
               state_nxt = M_STAT;
            end
         end
         T_EPC:   state_nxt = T_CAUSE;
         T_CAUSE: state_nxt = T_STAT;
         T_STAT:  state_nxt = T_VEC;
         T_VEC:   state_nxt = IDLE;
         M_STAT:  state_nxt = M_VEC;
         M_VEC:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. The redirect target only exists once the CSR file answers
   // in the vector cycle, so it is forwarded then and held by redir_pc_q after.
   always_comb begin
      csr_addr_o       = '0;
      csr_we_o         = 1'b0;
      csr_re_o         = 1'b0;
      csr_wdata_o      = '0;
      stall_o          = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = redir_pc_q;
      case (state)
         IDLE: begin
            // Combinational paths are forced low while reset is held.
            if (!rst_i) begin
               csr_addr_o  = core_csr_addr_i;
               csr_we_o    = core_csr_we_i;
               csr_re_o    = core_csr_re_i;
               csr_wdata_o = core_csr_wdata_i;
               flush_o     = pend;
            end
         end
         T_EPC: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_addr_o  = MEPC_ADDR;
            csr_wdata_o = epc_q;
         end
         T_CAUSE: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_addr_o  = MCAUSE_ADDR;
            csr_wdata_o = {1'b1, (DW-1)'(cause_q)};
         end
         T_STAT: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_addr_o  = MSTATUS_ADDR;
            csr_wdata_o = mstat_trap;
         end
         T_VEC: begin
            stall_o          = 1'b1;
            csr_re_o         = 1'b1;
            csr_addr_o       = MTVEC_ADDR;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = vec_target;
         end
         M_STAT: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            csr_addr_o  = MSTATUS_ADDR;
            csr_wdata_o = mstat_mret;
         end
         M_VEC: begin
            stall_o          = 1'b1;
            csr_re_o         = 1'b1;
            csr_addr_o       = MEPC_ADDR;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = csr_rdata_i;
         end
         default: begin
            stall_o = 1'b1;
         end
      endcase
   end

   // Shadows snoop every write on the CSR port; trap context and redirect hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mstatus_sh <= '0;
         meie_sh    <= 1'b0;
         mtie_sh    <= 1'b0;
         epc_q      <= '0;
         cause_q    <= '0;
         redir_pc_q <= '0;
      end else begin
         if (csr_we_o && (csr_addr_o == MSTATUS_ADDR)) begin
            mstatus_sh <= csr_wdata_o;
         end
         if (csr_we_o && (csr_addr_o == MIE_ADDR)) begin
            meie_sh <= csr_wdata_o[11];
            mtie_sh <= csr_wdata_o[7];
         end
         if ((state == IDLE) && pend) begin
            epc_q   <= pc_i;
            cause_q <= cause_sel;
         end
         if (redirect_valid_o) begin
            redir_pc_q <= redirect_pc_o;
         end
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl - randomized bench for trap_ctrl with a transaction-level model
// of the machine CSRs and a simple CSR file attached to the DUT port.
module tb_trap_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned ADDRW = 12;
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_SCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             irq_ext_i, irq_timer_i, mret_i;
   logic [DW-1:0]    pc_i;
   logic [ADDRW-1:0] core_csr_addr_i;
   logic             core_csr_we_i, core_csr_re_i;
   logic [DW-1:0]    core_csr_wdata_i;
   logic [ADDRW-1:0] csr_addr_o;
   logic             csr_we_o, csr_re_o;
   logic [DW-1:0]    csr_wdata_o, csr_rdata_i;
   logic             stall_o, flush_o, redirect_valid_o;
   logic [DW-1:0]    redirect_pc_o;

   int n_checks = 0;
   int n_errors = 0;

   // Architectural model of the CSRs the sequencer touches.
   logic [31:0] m_status, m_mie, m_mtvec, m_mepc, m_mcause, m_scratch;
   logic [31:0] last_redir;

   trap_ctrl dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .irq_ext_i        (irq_ext_i),
      .irq_timer_i      (irq_timer_i),
      .mret_i           (mret_i),
      .pc_i             (pc_i),
      .core_csr_addr_i  (core_csr_addr_i),
      .core_csr_we_i    (core_csr_we_i),
      .core_csr_re_i    (core_csr_re_i),
      .core_csr_wdata_i (core_csr_wdata_i),
      .csr_addr_o       (csr_addr_o),
      .csr_we_o         (csr_we_o),
      .csr_re_o         (csr_re_o),
      .csr_wdata_o      (csr_wdata_o),
      .csr_rdata_i      (csr_rdata_i),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   always #5 clk_i = ~clk_i;

   // CSR file on the DUT port: write on posedge, combinational read.
   logic [31:0] csr_mem [4096];
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
      end else if (csr_we_o) begin
         csr_mem[csr_addr_o] <= csr_wdata_o;
      end
   end
   assign csr_rdata_i = csr_re_o ? csr_mem[csr_addr_o] : '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_status = '0; m_mie = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0; m_scratch = '0;
      last_redir = '0;
   endtask

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         A_MSTATUS: m_status  = d;
         A_MIE:     m_mie     = d;
         A_MTVEC:   m_mtvec   = d;
         A_MEPC:    m_mepc    = d;
         A_MCAUSE:  m_mcause  = d;
         A_SCRATCH: m_scratch = d;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] trap_target(input logic [31:0] tv, input logic [3:0] c);
      logic [31:0] base;
      base = tv & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
      if (tv[1:0] == 2'b01) return base + 32'(c) * 4;
`endif
      return base;
   endfunction

   task automatic drive_idle();
      irq_ext_i = 0; irq_timer_i = 0; mret_i = 0; pc_i = '0;
      core_csr_addr_i = '0; core_csr_we_i = 0; core_csr_re_i = 0; core_csr_wdata_i = '0;
   endtask

   // Garbage on every input while the sequencer owns the port.
   task automatic drive_junk();
      irq_ext_i = 1'($urandom); irq_timer_i = 1'($urandom); mret_i = 1'($urandom);
      pc_i = $urandom; core_csr_addr_i = 12'($urandom); core_csr_we_i = 1'($urandom);
      core_csr_re_i = 1'($urandom); core_csr_wdata_i = $urandom;
   endtask

   task automatic compare_csrs();
      check("csr_mstatus", csr_mem[A_MSTATUS], m_status);
      check("csr_mie",     csr_mem[A_MIE],     m_mie);
      check("csr_mtvec",   csr_mem[A_MTVEC],   m_mtvec);
      check("csr_mepc",    csr_mem[A_MEPC],    m_mepc);
      check("csr_mcause",  csr_mem[A_MCAUSE],  m_mcause);
      check("csr_scratch", csr_mem[A_SCRATCH], m_scratch);
   endtask

   // One idle cycle of core CSR traffic; caller guarantees no interrupt is taken.
   task automatic core_access(input logic [11:0] a, input logic we, input logic re,
                              input logic [31:0] d, input logic ext);
      drive_idle();
      irq_ext_i = ext; pc_i = $urandom;
      core_csr_addr_i = a; core_csr_we_i = we; core_csr_re_i = re; core_csr_wdata_i = d;
      @(negedge clk_i);
      check("pass_bus", {csr_addr_o, csr_we_o, csr_re_o, csr_wdata_o}, {a, we, re, d});
      check("pass_ctl", {stall_o, flush_o, redirect_valid_o}, 3'b000);
      @(posedge clk_i); #1;
      if (we) model_write(a, d);
      drive_idle();
   endtask

   // One candidate trap/MRET cycle (optionally with a core write), then follow it.
   task automatic event_op(input logic ext, input logic tmr, input logic mret, input logic [31:0] pc,
                           input logic cw, input logic [11:0] ca, input logic [31:0] cd);
      logic        pend_exp;
      logic [3:0]  cause;
      int          lat_exp, got_lat, nstall;
      logic [31:0] tgt, got_pc;
      pend_exp = m_status[3] & ((ext & m_mie[11]) | (tmr & m_mie[7]));
      cause    = (ext & m_mie[11]) ? 4'd11 : 4'd7;
      drive_idle();
      irq_ext_i = ext; irq_timer_i = tmr; mret_i = mret; pc_i = pc;
      core_csr_addr_i = ca; core_csr_we_i = cw; core_csr_wdata_i = cd;
      @(negedge clk_i);
      check("accept_flush", flush_o, pend_exp);
      check("accept_stall", stall_o, 1'b0);
      check("accept_bus", {csr_addr_o, csr_we_o, csr_wdata_o}, {ca, cw, cd});
      @(posedge clk_i); #1;
      if (cw) model_write(ca, cd);
      lat_exp = 0;
      tgt     = last_redir;
      if (pend_exp) begin
         lat_exp  = 4;
         m_mepc   = pc;
         m_mcause = 32'h8000_0000 | 32'(cause);
         m_status = (m_status & ~32'h0000_1888) | 32'h0000_1800 | (m_status[3] ? 32'h80 : 32'h0);
         tgt      = trap_target(m_mtvec, cause);
      end else if (mret) begin
         lat_exp  = 2;
         m_status = (m_status & ~32'h0000_1888) | 32'h0000_1880 | (m_status[7] ? 32'h8 : 32'h0);
         tgt      = m_mepc;
      end
      if (lat_exp == 0) begin
         drive_idle();
         @(negedge clk_i);
         check("no_event", {stall_o, flush_o, redirect_valid_o, redirect_pc_o}, {3'b000, last_redir});
         @(posedge clk_i); #1;
      end else begin
         got_lat = 0; got_pc = '0; nstall = 0;
         for (int k = 1; k <= 8 && got_lat == 0; k++) begin
            drive_junk();
            @(negedge clk_i);
            if (stall_o) nstall++;
            if (redirect_valid_o) begin
               got_lat = k;
               got_pc  = redirect_pc_o;
            end
            @(posedge clk_i); #1;
         end
         drive_idle();
         check("redirect_latency", got_lat, lat_exp);
         check("redirect_pc", got_pc, tgt);
         check("stall_len", nstall, lat_exp);
         @(negedge clk_i);
         check("post_seq", {stall_o, redirect_valid_o, redirect_pc_o}, {2'b00, tgt});
         @(posedge clk_i); #1;
         compare_csrs();
         last_redir = tgt;
      end
   endtask

   task automatic do_reset();
      drive_idle();
      rst_i = 1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_outputs", {csr_addr_o, csr_we_o, csr_re_o, csr_wdata_o, stall_o, flush_o,
                              redirect_valid_o, redirect_pc_o}, '0);
      @(posedge clk_i); #1;
      rst_i = 0;
      model_reset();
   endtask

   function automatic logic [11:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return A_MSTATUS;
         1: return A_MIE;
         2: return A_MTVEC;
         3: return A_MEPC;
         4: return A_MCAUSE;
         default: return A_SCRATCH;
      endcase
   endfunction

   function automatic logic [31:0] pick_data(input logic [11:0] a);
      logic [31:0] d;
      d = $urandom;
      if (a == A_MSTATUS) d[3] = ($urandom_range(0, 9) < 7);
      return d;
   endfunction

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      logic [31:0] exp_vec;
      do_reset();

      // Basic external interrupt into a direct mtvec.
      core_access(A_MSTATUS, 1, 0, 32'h8, 0);
      core_access(A_MIE, 1, 0, 32'h800, 0);
      core_access(A_MTVEC, 1, 0, 32'h100, 0);
      event_op(1, 0, 0, 32'h40, 0, '0, '0);
      check("dir_mstatus", csr_mem[A_MSTATUS], 32'h1880);
      check("dir_mcause", csr_mem[A_MCAUSE], 32'h8000_000B);
      check("dir_mepc", csr_mem[A_MEPC], 32'h40);
      check("dir_target", last_redir, 32'h100);

      // mtvec mode bits.
      core_access(A_MSTATUS, 1, 0, 32'h8, 0);
      core_access(A_MTVEC, 1, 0, 32'h101, 0);
      event_op(1, 0, 0, 32'h40, 0, '0, '0);
`ifdef TRAP_VECTORED_EN
      exp_vec = 32'h12C;
`else
      exp_vec = 32'h100;
`endif
      check("vec_target", last_redir, exp_vec);

      // Both sources pending: external first, timer after MRET.
      core_access(A_MSTATUS, 1, 0, 32'h8, 0);
      core_access(A_MIE, 1, 0, 32'h880, 0);
      event_op(1, 1, 0, 32'h60, 0, '0, '0);
      check("prio_ext", csr_mem[A_MCAUSE], 32'h8000_000B);
      event_op(0, 1, 1, 32'h200, 0, '0, '0);
      event_op(0, 1, 0, 32'h64, 0, '0, '0);
      check("prio_tmr", csr_mem[A_MCAUSE], 32'h8000_0007);

      // Plain MRET.
      core_access(A_MSTATUS, 1, 0, 32'h1880, 0);
      core_access(A_MEPC, 1, 0, 32'h44, 0);
      event_op(0, 0, 1, 32'h300, 0, '0, '0);
      check("mret_mstatus", csr_mem[A_MSTATUS], 32'h1888);
      check("mret_target", last_redir, 32'h44);

      // Interrupt and MRET together: interrupt wins, MRET PC saved.
      core_access(A_MSTATUS, 1, 0, 32'h8, 0);
      core_access(A_MIE, 1, 0, 32'h800, 0);
      event_op(1, 0, 1, 32'h80, 0, '0, '0);
      check("both_mepc", csr_mem[A_MEPC], 32'h80);

      // Globally disabled: no trap, traffic still passes with irq high.
      core_access(A_MSTATUS, 1, 0, 32'h0, 1);
      event_op(1, 0, 0, 32'h90, 0, '0, '0);
      core_access(A_SCRATCH, 1, 0, 32'hDEAD_BEEF, 1);
      core_access(A_SCRATCH, 0, 1, 32'h0, 1);
      compare_csrs();

      // Reset while writing mcause.
      core_access(A_MSTATUS, 1, 0, 32'h8, 0);
      core_access(A_MIE, 1, 0, 32'h800, 0);
      irq_ext_i = 1; pc_i = 32'h70;
      @(negedge clk_i);
      check("rst_seq_flush", flush_o, 1'b1);
      @(posedge clk_i); #1;
      drive_idle();
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("rst_seq_in_cause", {stall_o, csr_we_o, csr_addr_o}, {1'b1, 1'b1, A_MCAUSE});
      #1 rst_i = 1;
      #1;
      check("rst_seq_outputs", {csr_addr_o, csr_we_o, csr_re_o, csr_wdata_o, stall_o, flush_o,
                                redirect_valid_o, redirect_pc_o}, '0);
      @(posedge clk_i); #1;
      rst_i = 0;
      model_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         check("rst_seq_quiet", {redirect_valid_o, stall_o}, 2'b00);
         @(posedge clk_i); #1;
      end

      // Randomized traffic.
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               a = pick_addr();
               core_access(a, 1, 0, pick_data(a), 0);
            end
            4: core_access(pick_addr(), 0, 1, 32'h0, 0);
            default: begin
               a = pick_addr();
               d = pick_data(a);
               event_op(1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                        ($urandom_range(0, 3) == 0), a, d);
            end
         endcase
      end
      compare_csrs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer. Sits directly upstream of csr_regs and owns its single CSR access port.
- Idle: passes core CSR-instruction accesses straight through to the CSR file.
- On an enabled interrupt or an MRET: stalls the pipeline, performs the multi-cycle CSR update sequence itself, then issues a single PC redirect to the fetch stage.

Parameters:
- DW, 32, data/PC width
- ADDRW, 12, CSR address width
- MSTATUS_ADDR, 12'h300, mstatus address
- MIE_ADDR, 12'h304, mie address
- MTVEC_ADDR, 12'h305, mtvec address
- MEPC_ADDR, 12'h341, mepc address
- MCAUSE_ADDR, 12'h342, mcause address

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset (see Behaviour)
- irq_ext_i  in  1  external interrupt, level
- irq_timer_i  in  1  timer interrupt, level
- mret_i  in  1  MRET in execute stage, one-cycle qualifier
- pc_i  in  DW  PC of instruction in execute stage
- core_csr_addr_i  in  ADDRW  core CSR address
- core_csr_we_i  in  1  core CSR write enable
- core_csr_re_i  in  1  core CSR read enable
- core_csr_wdata_i  in  DW  core CSR write data
- csr_addr_o  out  ADDRW  to CSR file
- csr_we_o  out  1  to CSR file
- csr_re_o  out  1  to CSR file
- csr_wdata_o  out  DW  to CSR file
- csr_rdata_i  in  DW  combinational read data from CSR file
- stall_o  out  1  freeze fetch/decode/execute
- flush_o  out  1  kill instructions younger than execute
- redirect_valid_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  DW  redirect target

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - State IDLE; mstatus shadow = 0.
  - stall_o, flush_o, redirect_valid_o = 0; redirect_pc_o = 0.
  - All csr_* outputs = 0.
  - Reset mid-sequence abandons the sequence immediately; no partial redirect is issued.
- Shadows:
  - Internal registered copies of mstatus (full DW) and mie bits 11 (MEIE) and 7 (MTIE).
  - Updated on any posedge where csr_we_o=1 to the matching address, whether the write comes from the core or from the FSM.
- Pending condition: pend = mstatus_sh[3] & ((irq_ext_i & MEIE) | (irq_timer_i & MTIE)).
  - Cause priority: external (11) over timer (7).
- IDLE:
  - csr_* outputs mirror core_csr_* combinationally; stall_o = 0.
  - If pend: capture pc_i and cause, assert flush_o combinationally this cycle, go to T_EPC.
  - Else if mret_i: go to M_STAT.
  - A core CSR write in the accept cycle still completes. The trap decision uses pre-write shadow values.
- Trap sequence (stall_o = 1 in every non-IDLE state; core_csr_* ignored):
  - T_EPC: write MEPC_ADDR = captured pc.
  - T_CAUSE: write MCAUSE_ADDR = {1'b1, (DW-1)'(cause)}, i.e. 32'h8000000B or 32'h80000007.
  - T_STAT: write MSTATUS_ADDR = shadow with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11.
  - T_VEC: re=1 at MTVEC_ADDR; redirect_pc_o = target (see Optional Feature); redirect_valid_o = 1 for exactly this cycle; next state IDLE.
- MRET sequence:
  - M_STAT: write mstatus with bit3 = old bit7, bit7 = 1, bits12:11 = 2'b11.
  - M_VEC: re=1 at MEPC_ADDR; redirect_pc_o = csr_rdata_i; redirect_valid_o = 1; next state IDLE.
- Latency:
  - Interrupt accept to redirect: 4 cycles.
  - MRET to redirect: 2 cycles.
- redirect_pc_o is registered and holds its last value between redirects.
- Boundary conditions:
  - Interrupt and mret_i in the same cycle: the interrupt wins; mepc = PC of the MRET, which re-executes after the handler returns.
  - irq deasserting mid-sequence has no effect.
  - No nesting: MIE is 0 after T_STAT, so pend stays low until software re-enables it.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if mtvec[1:0] == 2'b01, target = {mtvec[DW-1:2], 2'b00} + 4*cause; otherwise target = base.
- Undefined: target is always {mtvec[DW-1:2], 2'b00}; mode bits ignored.

Test Plan:
- Core writes mstatus=32'h8, mie=32'h800, mtvec=32'h100; pulse irq_ext_i with pc_i=32'h40 -> flush_o 1 cycle; writes mepc=32'h40, mcause=32'h8000000B, mstatus=32'h1880; redirect_pc_o=32'h100 four cycles after accept.
- Same setup with mtvec=32'h101, TRAP_VECTORED_EN defined -> redirect 32'h12C; undefined -> 32'h100.
- irq_ext_i and irq_timer_i both high, mie=32'h880 -> mcause=32'h8000000B; after MRET and ext deasserted, timer trap taken with mcause=32'h80000007.
- mret_i with mstatus=32'h1880, mepc=32'h44 -> mstatus written 32'h1888; redirect to 32'h44 two cycles later; stall_o high for exactly 2 cycles.
- mstatus MIE=0, irq_ext_i held high -> no flush, stall, or redirect; core CSR reads and writes pass through unchanged.
- rst_i asserted during T_CAUSE -> all outputs 0 immediately; no redirect_valid_o pulse after release.
